// File: rtl/mem_stage.sv
// Memory stage: serialises 1- or 4-byte little-endian loads/stores over a byte-wide RAM port,
// holds the pipeline while busy and registers the write-back triple.
module mem_stage #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    wa,
    input  logic          we,
    input  logic [31:0]   wn,
    input  logic [3:0]    ex_mem_e,
    input  logic [31:0]   ex_mem_a,
    input  logic [31:0]   ex_mem_n,
    input  logic [7:0]    ram_din,
    output logic [AW-1:0] ram_a,
    output logic          ram_wr,
    output logic [7:0]    ram_dout,
    output logic [4:0]    wa_o,
    output logic          we_o,
    output logic [31:0]   wn_o,
    output logic          stall_req
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RWAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_len;
    logic        r_zx;
    logic [4:0]  r_wa;
    logic        r_we;
    logic [23:0] r_buf;
    logic [4:0]  r_wa_o;
    logic        r_we_o;
    logic [31:0] r_wn_o;

    logic        w_req;
    logic        w_last;
    logic [31:0] w_sum;
    logic [31:0] w_shift;
    logic [31:0] w_load;

    assign w_req   = ex_mem_e[0];
    assign w_last  = (r_cnt == (r_len ? 2'd3 : 2'd0));
    assign w_sum   = r_addr + {30'd0, r_cnt};
    assign w_shift = r_data >> {r_cnt, 3'b000};

    // The final byte arrives in RWAIT and is merged straight from ram_din.
    always_comb begin
        w_load = {{24{ram_din[7]}}, ram_din};
        if (r_len)
            w_load = {ram_din, r_buf};
        else if (r_zx)
            w_load = {24'd0, ram_din};
    end

    always_comb begin
        w_next    = r_state;
        ram_a     = '0;
        ram_wr    = 1'b0;
        ram_dout  = 8'd0;
        stall_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    stall_req = 1'b1;
                    w_next    = ex_mem_e[2] ? S_WR : S_RD;
                end
            end
            S_RD: begin
                ram_a     = w_sum[AW-1:0];
                stall_req = 1'b1;
                if (w_last)
                    w_next = S_RWAIT;
            end
            S_RWAIT: begin
                stall_req = 1'b1;
                w_next    = S_DONE;
            end
            S_WR: begin
                ram_a     = w_sum[AW-1:0];
                ram_wr    = 1'b1;
                ram_dout  = w_shift[7:0];
                stall_req = 1'b1;
                if (w_last)
                    w_next = S_DONE;
            end
            S_DONE: begin
                // Always return to IDLE so a still-presented request is not replayed.
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (rst)
            stall_req = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_addr  <= 32'd0;
            r_data  <= 32'd0;
            r_len   <= 1'b0;
            r_zx    <= 1'b0;
            r_wa    <= 5'd0;
            r_we    <= 1'b0;
            r_buf   <= 24'd0;
            r_wa_o  <= 5'd0;
            r_we_o  <= 1'b0;
            r_wn_o  <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr <= ex_mem_a;
                        r_data <= ex_mem_n;
                        r_len  <= ex_mem_e[1];
                        r_zx   <= ex_mem_e[3];
                        r_wa   <= wa;
                        r_we   <= we;
                        r_cnt  <= 2'd0;
                        r_we_o <= 1'b0;
                    end else begin
                        r_wa_o <= wa;
                        r_we_o <= we;
                        r_wn_o <= wn;
                    end
                end
                S_RD: begin
                    // Byte cnt-1 was addressed last cycle and is on ram_din now.
                    case (r_cnt)
                        2'd1:    r_buf[7:0]   <= ram_din;
                        2'd2:    r_buf[15:8]  <= ram_din;
                        2'd3:    r_buf[23:16] <= ram_din;
                        default: ;
                    endcase
                    if (!w_last)
                        r_cnt <= r_cnt + 2'd1;
                end
                S_RWAIT: begin
                    r_wn_o <= w_load;
                    r_wa_o <= r_wa;
                    r_we_o <= r_we;
                end
                S_WR: begin
                    if (!w_last)
                        r_cnt <= r_cnt + 2'd1;
                    else
                        r_we_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign wa_o = r_wa_o;
    assign we_o = r_we_o;
    assign wn_o = r_wn_o;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset-mid-store sequence and randomized
// accesses checked against a byte-array RAM model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] wn;
    logic [3:0]  ex_mem_e;
    logic [31:0] ex_mem_a;
    logic [31:0] ex_mem_n;
    logic [7:0]  ram_din;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [4:0]  wa_o;
    logic        we_o;
    logic [31:0] wn_o;
    logic        stall_req;

    always #5 clk = ~clk;

    mem_stage #(.AW(32)) dut (
        .clk(clk), .rst(rst), .wa(wa), .we(we), .wn(wn),
        .ex_mem_e(ex_mem_e), .ex_mem_a(ex_mem_a), .ex_mem_n(ex_mem_n),
        .ram_din(ram_din), .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout),
        .wa_o(wa_o), .we_o(we_o), .wn_o(wn_o), .stall_req(stall_req)
    );

    // 1 KiB RAM aliased on the low address bits; read data appears the cycle after the address.
    logic [7:0] mem [0:1023];
    logic       pl_en = 1'b0;
    logic [9:0] pl_a  = 10'd0;
    logic [7:0] pl_d  = 8'd0;
    initial ram_din = 8'd0;
    always @(posedge clk) begin
        ram_din <= mem[ram_a[9:0]];
        if (pl_en)
            mem[pl_a] <= pl_d;
        else if (ram_wr)
            mem[ram_a[9:0]] <= ram_dout;
    end

    int pass_cnt = 0;
    int total    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    function automatic logic [31:0] model_load(input logic [3:0] e, input logic [31:0] a);
        logic [7:0]  b [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            t    = a + 32'(i);
            b[i] = mem[t[9:0]];
        end
        if (e[1])      return {b[3], b[2], b[1], b[0]};
        else if (e[3]) return {24'd0, b[0]};
        else           return {{24{b[0][7]}}, b[0]};
    endfunction

    int          obs_stall;
    logic [31:0] obs_ra [$];
    logic [31:0] obs_wa [$];
    logic [7:0]  obs_wd [$];

    // Drive one request, record every stall cycle, then check results at DONE
    // (or one cycle later for a pass-through).
    task automatic apply(input string tag, input logic [3:0] e, input logic [31:0] a,
                         input logic [31:0] n, input logic [4:0] w_a, input logic w_e,
                         input logic [31:0] w_n, input logic [31:0] exp_wn,
                         input logic exp_we, input int exp_stall);
        logic        done;
        int          nb;
        logic [31:0] ea [$];
        obs_stall = 0; obs_ra.delete(); obs_wa.delete(); obs_wd.delete();
        done = 1'b0;
        @(negedge clk);
        ex_mem_e = e; ex_mem_a = a; ex_mem_n = n; wa = w_a; we = w_e; wn = w_n;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (!stall_req) begin
                done = 1'b1;
                break;
            end
            obs_stall++;
            obs_ra.push_back(ram_a);
            if (ram_wr) begin
                obs_wa.push_back(ram_a);
                obs_wd.push_back(ram_dout);
            end
            @(negedge clk);
        end
        check({tag, " finished"}, 32'(done), 32'd1);
        if (!e[0]) begin
            @(negedge clk);
            #1;
        end
        check({tag, " stalls"}, 32'(obs_stall), 32'(exp_stall));
        nb = e[1] ? 4 : 1;
        if (e[0]) begin
            ea.push_back(32'd0);
            for (int i = 0; i < nb; i++) ea.push_back(a + 32'(i));
            if (!e[2]) ea.push_back(32'd0);
        end
        check({tag, " ram_a count"}, 32'(obs_ra.size()), 32'(ea.size()));
        if (obs_ra.size() == ea.size())
            for (int i = 0; i < ea.size(); i++)
                check($sformatf("%s ram_a[%0d]", tag, i), obs_ra[i], ea[i]);
        if (e[0] && e[2]) begin
            check({tag, " write count"}, 32'(obs_wa.size()), 32'(nb));
            if (obs_wa.size() == nb)
                for (int i = 0; i < nb; i++) begin
                    check($sformatf("%s wr_addr[%0d]", tag, i), obs_wa[i], a + 32'(i));
                    check($sformatf("%s wr_byte[%0d]", tag, i), 32'(obs_wd[i]), 32'((n >> (8 * i)) & 32'hFF));
                end
        end else begin
            check({tag, " write count"}, 32'(obs_wa.size()), 32'd0);
        end
        check({tag, " we_o"}, 32'(we_o), 32'(exp_we));
        if (!(e[0] && e[2])) begin
            check({tag, " wn_o"}, wn_o, exp_wn);
            check({tag, " wa_o"}, 32'(wa_o), 32'(w_a));
        end
        ex_mem_e = 4'd0;
    endtask

    typedef struct {
        logic [3:0]  e;
        logic [31:0] a;
        logic [31:0] n;
        logic [4:0]  wa;
        logic        we;
        logic [31:0] wn;
        logic [31:0] exp_wn;
        logic        exp_we;
        int          exp_stall;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{4'b0000, 32'h0,        32'h0,        5'd5,  1'b1, 32'h1234,     32'h1234,     1'b1, 0};
        tbl[1]  = '{4'b0011, 32'h100,      32'h0,        5'd7,  1'b1, 32'hAAAA,     32'h44332211, 1'b1, 6};
        tbl[2]  = '{4'b0001, 32'h20,       32'h0,        5'd3,  1'b1, 32'h0,        32'hFFFFFF80, 1'b1, 3};
        tbl[3]  = '{4'b1001, 32'h20,       32'h0,        5'd4,  1'b1, 32'h0,        32'h00000080, 1'b1, 3};
        tbl[4]  = '{4'b0111, 32'h200,      32'hDEADBEEF, 5'd9,  1'b1, 32'h0,        32'h0,        1'b0, 5};
        tbl[5]  = '{4'b0011, 32'hFFFFFFFE, 32'h0,        5'd10, 1'b1, 32'h0,        32'hD4C3B2A1, 1'b1, 6};
        tbl[6]  = '{4'b0011, 32'h200,      32'h0,        5'd11, 1'b1, 32'h0,        32'hDEADBEEF, 1'b1, 6};
        tbl[7]  = '{4'b1110, 32'h200,      32'h0,        5'd31, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 0};
        tbl[8]  = '{4'b0101, 32'h201,      32'h12345677, 5'd12, 1'b1, 32'h0,        32'h0,        1'b0, 2};
        tbl[9]  = '{4'b0011, 32'h200,      32'h0,        5'd13, 1'b1, 32'h0,        32'hDEAD77EF, 1'b1, 6};
        tbl[10] = '{4'b0001, 32'h201,      32'h0,        5'd14, 1'b1, 32'h0,        32'h00000077, 1'b1, 3};

        rst = 1'b1; ex_mem_e = 4'd0; ex_mem_a = 32'h0; ex_mem_n = 32'h0;
        wa = 5'd3; we = 1'b1; wn = 32'hFFFF;
        repeat (2) @(negedge clk);
        #1;
        check("reset wa_o", 32'(wa_o), 32'd0);
        check("reset we_o", 32'(we_o), 32'd0);
        check("reset wn_o", wn_o, 32'd0);
        check("reset ram_a", ram_a, 32'd0);
        check("reset ram_wr", 32'(ram_wr), 32'd0);
        check("reset ram_dout", 32'(ram_dout), 32'd0);
        check("reset stall_req", 32'(stall_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        preload(10'h100, 8'h11); preload(10'h101, 8'h22);
        preload(10'h102, 8'h33); preload(10'h103, 8'h44);
        preload(10'h020, 8'h80);
        preload(10'h3FE, 8'hA1); preload(10'h3FF, 8'hB2);
        preload(10'h000, 8'hC3); preload(10'h001, 8'hD4);

        for (int i = 0; i < 11; i++)
            apply($sformatf("vec%0d", i), tbl[i].e, tbl[i].a, tbl[i].n, tbl[i].wa, tbl[i].we,
                  tbl[i].wn, tbl[i].exp_wn, tbl[i].exp_we, tbl[i].exp_stall);

        // Reset during the second byte of a word store.
        preload(10'h302, 8'h5A); preload(10'h303, 8'h5A);
        @(negedge clk);
        ex_mem_e = 4'b0111; ex_mem_a = 32'h300; ex_mem_n = 32'h55667788; wa = 5'd1; we = 1'b1;
        #1 check("rstsw idle stall", 32'(stall_req), 32'd1);
        @(negedge clk);
        #1 check("rstsw wr0 addr", ram_a, 32'h300);
        check("rstsw wr0 byte", 32'(ram_dout), 32'h88);
        @(negedge clk);
        #1 check("rstsw wr1 strobe", 32'(ram_wr), 32'd1);
        check("rstsw wr1 addr", ram_a, 32'h301);
        rst = 1'b1; ex_mem_e = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstsw ram_wr", 32'(ram_wr), 32'd0);
        check("rstsw stall_req", 32'(stall_req), 32'd0);
        check("rstsw ram_a", ram_a, 32'd0);
        check("rstsw ram_dout", 32'(ram_dout), 32'd0);
        check("rstsw outs", {26'd0, wa_o, we_o}, 32'd0);
        check("rstsw wn_o", wn_o, 32'd0);
        repeat (2) @(negedge clk);
        check("rstsw byte2 kept", 32'(mem[10'h302]), 32'h5A);
        check("rstsw byte3 kept", 32'(mem[10'h303]), 32'h5A);
        apply("sb after reset", 4'b0101, 32'h10, 32'h000000AB, 5'd2, 1'b1, 32'h0, 32'h0, 1'b0, 2);
        check("sb after reset mem", 32'(mem[10'h010]), 32'hAB);

        for (int k = 0; k < 40; k++) begin
            logic [3:0]  e;
            logic [31:0] a, n, w_n, exp_wn;
            logic [4:0]  w_a;
            logic        w_e, exp_we;
            int          nb, exp_st;
            e   = 4'($urandom_range(0, 15));
            a   = (k % 3 == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
            n   = $urandom;
            w_n = $urandom;
            w_a = 5'($urandom);
            w_e = 1'($urandom);
            nb  = e[1] ? 4 : 1;
            if (!e[0]) begin
                exp_wn = w_n; exp_we = w_e; exp_st = 0;
            end else if (e[2]) begin
                exp_wn = 32'h0; exp_we = 1'b0; exp_st = nb + 1;
            end else begin
                exp_wn = model_load(e, a); exp_we = w_e; exp_st = nb + 2;
            end
            apply($sformatf("rand%0d", k), e, a, n, w_a, w_e, w_n, exp_wn, exp_we, exp_st);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage: consumes the execute stage's result and memory-request outputs (ex_mem_e, ex_mem_n, write-back triple) and performs loads and stores over the byte-wide RAM port.
- Serialises 1- or 4-byte accesses little-endian, stalls the pipeline while busy, and presents the registered write-back triple to the write-back stage.

Parameters:
- AW, 32, RAM address width; ram_a is the low AW bits of the computed byte address.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wa  in  5  destination register from execute stage
- we  in  1  register write enable from execute stage
- wn  in  32  ALU result from execute stage
- ex_mem_e  in  4  request control, fields below
- ex_mem_a  in  32  byte address of the access
- ex_mem_n  in  32  store data; only [7:0] used for byte stores
- ram_din  in  8  RAM read byte, valid the cycle after its address
- ram_a  out  AW  RAM byte address
- ram_wr  out  1  RAM write strobe, 1 = write
- ram_dout  out  8  RAM write byte
- wa_o  out  5  write-back register
- we_o  out  1  write-back enable
- wn_o  out  32  write-back data
- stall_req  out  1  pipeline hold request (combinational)

ex_mem_e fields:
- [0] enable; when 0, [3:1] are ignored.
- [1] length: 0 = 1 byte, 1 = 4 bytes.
- [2] direction: 0 = read, 1 = write.
- [3] byte-load zero-extend: 0 = sign-extend, 1 = zero-extend. Ignored for words and writes.

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE, byte counter 0.
  - wa_o, we_o, wn_o = 0; ram_a = 0; ram_wr = 0; ram_dout = 0; stall_req = 0.
  - Reset mid-access abandons it; no ram_wr pulse after the reset edge.
- States: IDLE, RD, RWAIT, WR, DONE. N = 1 or 4 bytes.
- IDLE, ex_mem_e[0] = 0:
  - Register wa/we/wn into wa_o/we_o/wn_o at the edge; latency 1.
  - stall_req = 0.
- IDLE, ex_mem_e[0] = 1:
  - stall_req = 1 this cycle.
  - At the edge, latch address, data, length, zero-extend flag, wa and we; set cnt = 0; go to RD (read) or WR (write).
  - we_o = 0 at that edge (bubble).
- RD:
  - ram_a = addr + cnt; ram_wr = 0.
  - From the second RD cycle on, capture ram_din into byte cnt-1 of the load buffer.
  - After N cycles go to RWAIT.
- RWAIT:
  - Capture the last byte.
  - At the edge: wn_o = assembled value (byte load extended per [3]), wa_o = latched wa, we_o = latched we.
  - Go to DONE.
- WR:
  - ram_a = addr + cnt; ram_wr = 1; ram_dout = byte cnt of the latched data, byte 0 first.
  - After N cycles go to DONE with we_o = 0.
- DONE:
  - stall_req = 0; outputs hold; inputs ignored.
  - Next state IDLE, so the same request never retriggers.
- stall_req = 1 in IDLE-with-request, RD, RWAIT and WR; 0 otherwise.
- Stall cycles per access:
  - LW: 6 (IDLE, RD×4, RWAIT)
  - LB/LBU: 3
  - SW: 5
  - SB: 2
- Upstream holds all inputs stable while stall_req = 1.
- Address arithmetic is modulo 2^32; no alignment check. Misaligned words are legal; 0xFFFFFFFF wraps to 0.
- Outside WR, ram_wr = 0 and ram_dout = 0. Outside RD/WR, ram_a = 0.

Test Plan:
- Pass-through: ex_mem_e = 0, wa = 5, we = 1, wn = 0x1234 -> next cycle wa_o = 5, we_o = 1, wn_o = 0x1234; stall_req never asserted.
- LW: RAM[0x100..0x103] = 11,22,33,44, ex_mem_e = 4'b0011, addr 0x100 -> ram_a 0x100..0x103 on consecutive cycles; stall_req high 6 cycles; DONE shows wn_o = 0x44332211, we_o = 1.
- LB/LBU: RAM[0x20] = 0x80 -> ex_mem_e = 4'b0001 gives wn_o = 0xFFFFFF80; ex_mem_e = 4'b1001 gives 0x00000080; 3 stall cycles each.
- SW: ex_mem_e = 4'b0111, addr 0x200, data 0xDEADBEEF -> four ram_wr cycles with (0x200,EF), (0x201,BE), (0x202,AD), (0x203,DE); we_o = 0; 5 stall cycles.
- Wrap: LW at 0xFFFFFFFE -> ram_a sequence FFFFFFFE, FFFFFFFF, 0, 1.
- Reset mid-SW: rst high during the 2nd WR cycle -> next cycle state IDLE, ram_wr = 0, stall_req = 0, all outputs 0; a following SB at 0x10 completes normally in 2 stall cycles.
